rs232_rx_buffered: RTL

//  Buffered RS-232 receiver. Sits between the RxD pin and the processor I/O decode (I/O word 2 data, word 3 status).

---
 rtl/rs232_pkg.sv | 19 +
 rtl/rs232_fifo.sv | 62 ++++++
 rtl/rs232_rx_buffered.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: receiver FSM encoding, bit-period helper, I/O word map.
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int RX_DATA = 2;
    localparam int RX_STAT = 3;

    function automatic int ticks(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rs232_fifo.sv
// Synchronous byte queue with head-of-queue read data, fill count and full/empty.
// Latency: a push is visible at the head on the next cycle; pop advances the head next cycle.
// Backpressure: push while full (and no pop) is dropped; pop while empty is ignored.
module rs232_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A pop on a full queue frees the slot the simultaneous push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rs232_rx_buffered.sv
// 8N1 serial receiver feeding a byte queue polled over the I/O bus.
// Latency: byte visible the cycle after the stop-bit sample; RxD is 2-flop synchronised.
// Backpressure: none on the line; bytes arriving while the queue is full are dropped and flagged in ovf.
module rs232_rx_buffered
    import rs232_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 19200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RxD,
    input  logic                  done,
    input  logic                  clrerr,
    output logic [7:0]            data,
    output logic                  rdy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf,
    output logic                  ferr
);

    localparam int TICKS = ticks(CLK_HZ, BAUD);
    localparam int HALF  = TICKS / 2;
    localparam int TW    = $clog2(TICKS + 1);

    logic [1:0]    sync;
    logic          rx;
    rx_state_t     state;
    rx_state_t     state_nx;
    logic [TW-1:0] tick;
    logic [TW-1:0] tick_nx;
    logic [3:0]    bitn;
    logic [3:0]    bitn_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic          push;
    logic          ferr_set;
    logic          ovf_set;
    logic          full;
    logic          empty;

    assign rx = sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= 2'b11;
            state <= IDLE;
            tick  <= '0;
            bitn  <= '0;
            shreg <= '0;
        end else begin
            sync  <= {sync[0], RxD};
            state <= state_nx;
            tick  <= tick_nx;
            bitn  <= bitn_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick + TW'(1);
        bitn_nx  = bitn;
        shreg_nx = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: begin
                tick_nx = '0;
                if (!rx) begin
                    state_nx = START;
                end
            end
            START: begin
                if (tick == TW'(HALF - 1)) begin
                    tick_nx  = '0;
                    bitn_nx  = '0;
                    state_nx = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick == TW'(TICKS - 1)) begin
                    tick_nx  = '0;
                    shreg_nx = {rx, shreg[7:1]};
                    bitn_nx  = bitn + 4'd1;
                    if (bitn == 4'd7) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (tick == TW'(TICKS - 1)) begin
                    tick_nx = '0;
                    if (rx) begin
                        push     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_nx = BREAK;
                    end
                end
            end
            BREAK: begin
                tick_nx = '0;
                if (rx) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                tick_nx  = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // A pop in the same cycle makes room, so only an unaccompanied push to a full queue overflows.
    assign ovf_set = push & full & ~done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clrerr) begin
                ovf <= 1'b0;
            end
            if (ferr_set) begin
                ferr <= 1'b1;
            end else if (clrerr) begin
                ferr <= 1'b0;
            end
        end
    end

    rs232_fifo #(
        .AW (DEPTH_LOG2),
        .W  (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (done),
        .wdata (shreg),
        .rdata (data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign rdy = ~empty;

endmodule
